// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int   PS2_DATA_BITS = 8;
  localparam logic PS2_IDLE      = 1'b1;

endpackage

// File: rtl/ps2_sync_edge.sv
// Multi-stage synchronizer for one PS/2 line with a falling-edge pulse.
module ps2_sync_edge
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // Reset to the idle-high level so no spurious edge appears after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= {SYNC_STAGES{PS2_IDLE}};
      prev <= PS2_IDLE;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], line};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign fall  = prev & ~level;

endmodule

// File: rtl/ps2_rx_controller.sv
// PS/2 keyboard receive controller: 11-bit frame FSM, timeout, sticky error flags.
module ps2_rx_controller
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       buf_full,
  input  logic       err_clear,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       frame_err,
  output logic       overflow
);

  localparam int             TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic clk_fall, clk_level_unused;
  logic data_level, data_fall_unused;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk   (clk),
    .reset (reset),
    .line  (ps2_clk),
    .level (clk_level_unused),
    .fall  (clk_fall)
  );

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk   (clk),
    .reset (reset),
    .line  (ps2_data),
    .level (data_level),
    .fall  (data_fall_unused)
  );

  ps2_state_t               state, state_nx;
  logic [2:0]               bit_cnt, bit_cnt_nx;
  logic [PS2_DATA_BITS-1:0] shift, shift_nx;
  logic                     par_ok, par_ok_nx;
  logic [TW-1:0]            to_cnt, to_cnt_nx;
  logic                     wr_en_nx;
  logic [7:0]               wr_data_nx;
  logic                     err_set, ovf_set;

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
    par_ok_nx  = par_ok;
    to_cnt_nx  = (state == IDLE) ? '0 : to_cnt + TW'(1);
    wr_en_nx   = 1'b0;
    wr_data_nx = '0;
    err_set    = 1'b0;
    ovf_set    = 1'b0;

    if (clk_fall) begin
      to_cnt_nx = '0;
      case (state)
        IDLE: begin
          if (!data_level) begin
            state_nx   = DATA;
            bit_cnt_nx = '0;
          end
        end
        DATA: begin
          shift_nx   = {data_level, shift[PS2_DATA_BITS-1:1]};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'(PS2_DATA_BITS - 1)) state_nx = PARITY;
        end
        PARITY: begin
          par_ok_nx = ^{shift, data_level};
          state_nx  = STOP;
        end
        STOP: begin
          state_nx = IDLE;
          if (!data_level || !par_ok) begin
            err_set = 1'b1;
          end else if (buf_full) begin
            ovf_set = 1'b1;
          end else begin
            wr_en_nx   = 1'b1;
            wr_data_nx = shift;
          end
        end
        default: state_nx = IDLE;
      endcase
    end else if (state != IDLE && to_cnt == TO_LAST) begin
      // Line stalled mid-frame: abandon the partial byte.
      state_nx  = IDLE;
      err_set   = 1'b1;
      to_cnt_nx = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par_ok    <= 1'b0;
      to_cnt    <= '0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      shift   <= shift_nx;
      par_ok  <= par_ok_nx;
      to_cnt  <= to_cnt_nx;
      wr_en   <= wr_en_nx;
      wr_data <= wr_data_nx;
      // A new error event outranks a simultaneous clear.
      if (err_set)        frame_err <= 1'b1;
      else if (err_clear) frame_err <= 1'b0;
      if (ovf_set)        overflow  <= 1'b1;
      else if (err_clear) overflow  <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_rx_controller.sv
// Randomized PS/2 frame stimulus checked against a frame-level model of the receiver.
module tb_ps2_rx_controller;

  localparam int SYNC = 2;
  localparam int TO   = 300;
  localparam int H    = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       buf_full = 1'b0;
  logic       err_clear = 1'b0;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       busy, frame_err, overflow;

  ps2_rx_controller #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .buf_full  (buf_full),
    .err_clear (err_clear),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .busy      (busy),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] wr_log[$];
  logic       m_err = 1'b0;
  logic       m_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] log_at(input int i);
    if (i >= 0 && i < wr_log.size()) return wr_log[i];
    return 8'hxx;
  endfunction

  // Write stream compare: every cycle out of reset.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        wr_log.push_back(wr_data);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wr_unexpected: got write of %0h, required no write", wr_data);
        end else begin
          chk("wr_data", {24'd0, wr_data}, {24'd0, exp_q.pop_front()});
        end
      end else begin
        chk("wr_data_idle", {24'd0, wr_data}, 32'd0);
      end
    end
  end

  task automatic ps2_bit(input logic b, input logic clr_at_edge);
    @(posedge clk); #1 ps2_data = b;
    repeat (H) @(posedge clk);
    #1 ps2_clk = 1'b0;
    if (clr_at_edge) begin
      // Clear lands on the cycle the FSM consumes this edge.
      repeat (2) @(posedge clk);
      #1 err_clear = 1'b1;
      @(posedge clk);
      #1 err_clear = 1'b0;
      repeat (H - 3) @(posedge clk);
    end else begin
      repeat (H) @(posedge clk);
    end
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop_bad,
                            input logic full, input logic clr);
    logic        par;
    logic [10:0] f;
    par = (~^d) ^ par_bad;
    f   = {~stop_bad, par, d, 1'b0};
    if (clr) begin
      m_err = 1'b0;
      m_ovf = 1'b0;
    end
    if (par_bad || stop_bad) m_err = 1'b1;
    else if (full)           m_ovf = 1'b1;
    else                     exp_q.push_back(d);
    buf_full = full;
    for (int i = 0; i < 11; i++) ps2_bit(f[i], clr && (i == 10));
    buf_full = 1'b0;
  endtask

  task automatic settle_check(input string tag);
    repeat (5) @(posedge clk);
    #1;
    chk({tag, "_frame_err"}, {31'd0, frame_err}, {31'd0, m_err});
    chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, m_ovf});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
    m_err = 1'b0;
    m_ovf = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int         base;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk);

    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    settle_check("valid");
    chk("valid_count", wr_log.size(), 32'd1);
    chk("valid_byte", {24'd0, log_at(0)}, 32'h1C);

    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
    settle_check("parity");
    chk("parity_err_lit", {31'd0, frame_err}, 32'd1);
    chk("parity_count", wr_log.size(), 32'd1);
    pulse_clear();
    settle_check("parity_clr");

    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    settle_check("b2b");
    chk("b2b_count", wr_log.size(), 32'd3);
    chk("b2b_first", {24'd0, log_at(1)}, 32'hF0);
    chk("b2b_second", {24'd0, log_at(2)}, 32'h1C);

    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b1, 1'b0);
    #1;
    chk("timeout_busy_mid", {31'd0, busy}, 32'd1);
    repeat (TO + 10) @(posedge clk);
    m_err = 1'b1;
    settle_check("timeout");
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    settle_check("timeout_next");
    chk("timeout_next_byte", {24'd0, log_at(3)}, 32'h1C);
    pulse_clear();

    send_frame(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0);
    settle_check("ovf");
    chk("ovf_lit", {31'd0, overflow}, 32'd1);
    chk("ovf_count", wr_log.size(), 32'd4);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1, 1'b1);
    settle_check("ovf_clr_same");
    chk("ovf_clr_lit", {31'd0, overflow}, 32'd1);
    pulse_clear();
    settle_check("ovf_cleared");

    ps2_bit(1'b1, 1'b0);
    settle_check("glitch");
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b1, 1'b0);
    #1;
    chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_mid_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_mid_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    m_err = 1'b0;
    m_ovf = 1'b0;
    repeat (3) @(posedge clk);
    base = wr_log.size();
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    settle_check("rst_next");
    chk("rst_next_byte", {24'd0, log_at(base)}, 32'h1C);

    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) ps2_bit(1'b1, 1'b0);
      if ($urandom_range(0, 4) == 0) pulse_clear();
      send_frame(d, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
      settle_check("rand");
    end

    chk("pending_writes", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_rx_controller.md
# ps2_rx_controller

Sequencing controller for the PS/2 keyboard receive path. It synchronizes the raw PS/2 clock and data lines into the system clock domain and runs the 11-bit frame state machine: start, 8 data bits LSB-first, odd parity, stop. Each validated scan-code byte is issued to the 32-entry character buffer as a single-cycle write. Frame errors, timeouts and buffer overflow are reported as sticky flags for the keyboard peripheral's status register.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of the PS/2 line synchronizers (minimum 2).
- `TIMEOUT_CYCLES`, 5000: maximum number of `clk` cycles allowed between consecutive PS/2 falling edges inside a frame.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `ps2_clk` in 1: raw PS/2 clock; asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data; asynchronous to `clk`.
- `buf_full` in 1: character buffer has no free entry.
- `err_clear` in 1: one-cycle pulse that clears `frame_err` and `overflow`.
- `wr_en` out 1: one-cycle write strobe to the character buffer.
- `wr_data` out 8: received byte; valid only while `wr_en`=1.
- `busy` out 1: high while a frame is in progress (any state other than IDLE).
- `frame_err` out 1: sticky; set on bad parity, bad stop bit or timeout.
- `overflow` out 1: sticky; set when a valid byte is dropped because `buf_full`=1.

## Operation
- Bits are sampled only on a detected falling edge of the synchronized `ps2_clk`, using the synchronized `ps2_data`.
- States:
  - IDLE:
    - A falling edge with data=0 goes to DATA and clears the bit counter.
    - A falling edge with data=1 is ignored: stay in IDLE, no error.
  - DATA: shift the data bit into `shift[7]` and shift right. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit. `par_ok` = (XOR of shift[7:0] XOR bit) == 1. Go to STOP.
  - STOP: on the edge, return to IDLE and resolve the frame:
    - data=0 or !par_ok: set `frame_err`, no write.
    - Frame valid and `buf_full`=0: pulse `wr_en` with `wr_data`=shift.
    - Frame valid and `buf_full`=1: set `overflow`, no write.
- Timeout counter:
  - Clears on every falling edge.
  - Counts while not in IDLE.
  - Reaching `TIMEOUT_CYCLES`: abort to IDLE and set `frame_err`.
- `err_clear` coinciding with a new error event: the set wins, and the flag stays 1.
- `buf_full` is sampled only on the cycle the stop bit resolves.
- `reset` mid-frame: the partial frame is discarded, the FSM returns to IDLE and all outputs go to 0.

## Timing
- Reset values:
  - `wr_en`=0, `wr_data`=0x00, `busy`=0, `frame_err`=0, `overflow`=0.
  - Synchronizers and edge-detect history are reset to 1 (PS/2 idle-high).
- Input latency: a PS/2 line change is seen by the FSM SYNC_STAGES+1 cycles later (synchronizer plus edge register).
- `wr_en` is registered and is high for exactly one cycle: the cycle after the FSM processes the stop-bit edge.
- `wr_data` holds the byte for that cycle and is 0x00 otherwise.
- `frame_err` and `overflow` are registered and become visible on the cycle after the causing event.
- `busy` rises the cycle after the start-bit edge is processed and falls the cycle after stop or abort.
- Timeout abort fires on the cycle the counter equals `TIMEOUT_CYCLES`-1.
- Back-to-back frames are accepted with zero idle cycles. At most one write can occur per frame, so at most one `wr_en` per 11 PS/2 edges.

## Structure
- Shared package `ps2_pkg`:
  - State enum: IDLE, DATA, PARITY, STOP.
  - `PS2_DATA_BITS`=8.
  - Idle line level `PS2_IDLE`=1'b1.
- Sub-module `ps2_sync_edge`: a SYNC_STAGES synchronizer for one line plus a falling-edge pulse output. Instantiate it twice, once for clock and once for data; use only the level output of the data instance.
- The top level contains the FSM, bit counter (3 bits), shift register, timeout counter ($clog2(TIMEOUT_CYCLES) bits) and flag logic.

## Test plan
- Valid frame 0x1C: start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1, `buf_full`=0. Expect exactly one `wr_en` with `wr_data`=0x1C, and `frame_err`=`overflow`=0.
- Parity error: 0x1C sent with parity 1. Expect no `wr_en` and `frame_err`=1. Then pulse `err_clear`: `frame_err`=0.
- Back-to-back 0xF0 (parity 1) then 0x1C with no gap. Expect two `wr_en` pulses, 0xF0 then 0x1C.
- Timeout: start bit plus 4 data bits, then `ps2_clk` held high for `TIMEOUT_CYCLES`+10 cycles. Expect `frame_err`=1 and `busy`=0. A following 0x1C frame writes 0x1C.
- Overflow: valid 0x1C with `buf_full`=1. Expect no `wr_en` and `overflow`=1. Assert `err_clear` on the same cycle as a second overflow: `overflow` stays 1.
- Glitch and reset: a falling edge with data=1 in IDLE gives `busy`=0 and no error. `reset` after 5 data bits gives all outputs 0. The next 0x1C frame is received correctly.
